// File: rtl/pow_cube_pkg.sv
// Shared types and sizing helpers for the handshaked square/cube unit.
package pow_cube_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        DONE
    } state_t;

    function automatic int unsigned res_w(input int unsigned width);
        return 3 * width;
    endfunction

endpackage

// File: rtl/pow_mul.sv
// Combinational unsigned multiplier, WIDTH x 2*WIDTH -> 3*WIDTH, shared by both passes.
module pow_mul
    import pow_cube_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned RES_W = res_w(WIDTH)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0] b,
    output logic [RES_W-1:0]   p
);

    always_comb begin
        p = {{(RES_W - WIDTH){1'b0}}, a} * {{(RES_W - 2 * WIDTH){1'b0}}, b};
    end

endmodule

// File: rtl/pow_cube_unit.sv
// Handshaked A^2 / A^3 unit: one shared multiplier used over one (square) or two (cube) passes.
module pow_cube_unit
    import pow_cube_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned RES_W = res_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cube,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic             busy
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 mode_q, mode_d;
    logic [RES_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic [2*WIDTH-1:0]   mul_b;
    logic [RES_W-1:0]     product;

    // Second pass multiplies the stored square by A; first pass squares A.
    always_comb begin
        mul_b = (state_q == MUL2) ? acc_q : {{WIDTH{1'b0}}, op_q};
    end

    pow_mul #(.WIDTH(WIDTH)) u_mul (
        .a (op_q),
        .b (mul_b),
        .p (product)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = in_data;
                    mode_d     = in_cube;
                    state_d    = MUL1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            MUL1: begin
                acc_d = product[2*WIDTH-1:0];
                if (mode_q) begin
                    state_d = MUL2;
                end else begin
                    out_data_d  = {{WIDTH{1'b0}}, product[2*WIDTH-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            MUL2: begin
                out_data_d  = product;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pow_cube_unit.sv
// Bench for pow_cube_unit: WIDTH=2 cube sweep plus a WIDTH=8 instance checked against a latency model.
module tb_pow_cube_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_cube, out_valid, out_ready, busy;
    logic [7:0]  in_data;
    logic [23:0] out_data;

    logic        in_valid2, in_ready2, in_cube2, out_valid2, out_ready2, busy2;
    logic [1:0]  in_data2;
    logic [5:0]  out_data2;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    longint unsigned res_q[$];

    always #5 clk = ~clk;

    pow_cube_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cube(in_cube),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    pow_cube_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_cube(in_cube2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint unsigned pow_ref(input longint unsigned a, input bit c);
        return c ? a * a * a : a * a;
    endfunction

    // Model: an accepted operand becomes visible after 1 (square) or 2 (cube) edges,
    // stays until consumed, then the unit is free again.
    bit              m_idle, m_valid;
    int              m_cnt;
    longint unsigned m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_valid = 1'b0; m_cnt = 0; m_res = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0; m_idle = 1'b1;
            end
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_res  = pow_ref(in_data, in_cube);
                m_cnt  = in_cube ? 2 : 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end
    end

    bit              hold_q;
    longint unsigned hold_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q = 1'b0; hold_data = 0;
        end else begin
            hold_q    = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) res_q.push_back(out_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", in_ready, m_idle);
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, !m_idle);
            if (m_valid) chk("out_data", out_data, m_res);
            if (hold_q) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic c);
        bit r, ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = a; in_cube = c;
        for (int i = 0; i < 50; i++) begin
            r = in_ready;
            tick();
            if (r) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic get_result(input string name, input longint unsigned exp);
        bit got;
        for (int i = 0; i < 50; i++) begin
            if (res_q.size() > 0) break;
            tick();
        end
        got = (res_q.size() > 0);
        chk({name, "_arrive"}, got, 1);
        if (got) chk(name, res_q.pop_front(), exp);
    endtask

    int cube2[4] = '{0, 1, 8, 27};

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_cube = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_cube2 = 1'b1; out_ready2 = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst2_out_data", out_data2, 0);
        chk("rst2_in_ready", in_ready2, 1);
        chk("pin_cube255", pow_ref(255, 1), 16581375);
        chk("pin_sq255", pow_ref(255, 0), 65025);
        chk("pin_cube12", pow_ref(12, 1), 1728);
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // WIDTH=2 cube sweep: valid on 3rd cycle after accept, ready low for 3 cycles
        for (int a = 0; a < 4; a++) begin
            chk("w2_ready_idle", in_ready2, 1);
            in_valid2 = 1'b1; in_data2 = a[1:0];
            tick();
            in_valid2 = 1'b0;
            for (int c = 0; c < 4; c++) begin
                chk("w2_ready", in_ready2, (c == 3) ? 1 : 0);
                chk("w2_valid", out_valid2, (c == 2) ? 1 : 0);
                if (c == 2) chk("w2_data", out_data2, cube2[a]);
                if (c < 3) tick();
            end
        end

        send(8'd255, 1'b1);
        get_result("cube255", 24'hFD02FF);

        send(8'd255, 1'b0);
        chk("sq_lat_n1", out_valid, 0);
        tick();
        chk("sq_lat_n2", out_valid, 1);
        get_result("sq255", 24'h00FE01);

        // Backpressure with an ignored concurrent operand
        out_ready = 1'b0;
        send(8'd10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("bp_valid_rise", out_valid, 1);
        in_valid = 1'b1; in_data = 8'd3; in_cube = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 1000);
            chk("bp_ready_low", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        get_result("bp10", 1000);
        chk("bp_no_extra", res_q.size(), 0);

        send(8'd12, 1'b0);
        send(8'd12, 1'b1);
        get_result("il_sq12", 144);
        get_result("il_cube12", 1728);

        // Asynchronous reset while the cube of 7 is in its second pass
        send(8'd7, 1'b1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_stale", res_q.size(), 0);
        chk("post_rst_ready", in_ready, 1);
        send(8'd2, 1'b1);
        get_result("post_rst_cube2", 8);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_cube   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
